// File: rtl/dram_reset_seq.sv
`timescale 1ns/1ps
// dram_reset_seq
// Sequences the DRAM PHY out of reset and supervises calibration. After
// power-on reset or a software strobe, the PHY is held in reset for
// RST_CYCLES cycles. The block then waits up to CAL_TIMEOUT cycles for the
// PHY to report calibration done. It then either holds READY or latches FAIL.
//
// Ports
//   wb_clk_i        in   single clock, rising edge
//   wb_rst_n_i      in   active-low reset, asserted asynchronously, released synchronously
//   dram_reset_strb in   one-cycle software request to rerun the reset sequence
//   phy_init_done   in   PHY calibration-complete level (asynchronous)
//   phy_rst_o       out  active-high reset to the DRAM PHY/controller
//   phy_ready       out  calibration complete and still held
//   cal_fail        out  calibration timed out or was lost (sticky)
//   busy            out  reset sequence in progress
module dram_reset_seq #(
    parameter int unsigned RST_CYCLES  = 64,
    parameter int unsigned CAL_TIMEOUT = 1000000
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n_i,
    input  logic dram_reset_strb,
    input  logic phy_init_done,
    output logic phy_rst_o,
    output logic phy_ready,
    output logic cal_fail,
    output logic busy
);

    localparam int unsigned CNT_MAX = (1 << 24) - 1;

    generate
        if (RST_CYCLES < 1 || RST_CYCLES > CNT_MAX) begin : g_bad_rst_cycles
            $error("dram_reset_seq: RST_CYCLES must be within 1..2^24-1");
        end
        if (CAL_TIMEOUT < 4 || CAL_TIMEOUT > CNT_MAX) begin : g_bad_cal_timeout
            $error("dram_reset_seq: CAL_TIMEOUT must be within 4..2^24-1");
        end
    endgenerate

    localparam logic [23:0] HOLD_LAST = 24'(RST_CYCLES - 1);
    localparam logic [23:0] CAL_LAST  = 24'(CAL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_CAL = 2'd1,
        READY    = 2'd2,
        FAIL     = 2'd3
    } state_t;

    // Packed output order: {phy_rst_o, busy, phy_ready, cal_fail}
    function automatic logic [3:0] decode(input state_t s);
        case (s)
            HOLD:     return 4'b1100;
            WAIT_CAL: return 4'b0100;
            READY:    return 4'b0010;
            default:  return 4'b0001;
        endcase
    endfunction

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    // Reset synchronizer: assertion reaches the logic immediately. Release
    // is retimed through two flops, so the whole block leaves reset on a
    // clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // phy_init_done comes from the PHY clock domain
    logic [1:0] init_sync;
    logic       init;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)
            init_sync <= 2'b00;
        else
            init_sync <= {init_sync[0], phy_init_done};
    end

    assign init = init_sync[1];

    state_t      state;
    logic [23:0] count;
    logic        armed;
    logic [3:0]  out_q;

    // Outputs are loaded from the decode of the state being entered, so
    // they change on the same edge as the state and never depend on inputs
    // combinationally. "armed" latches the first low init seen in WAIT_CAL.
    // A done level left over from before the reset is therefore not
    // mistaken for a fresh calibration.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            count <= '0;
            armed <= 1'b0;
            out_q <= decode(HOLD);
        end else if (dram_reset_strb) begin
            state <= HOLD;
            count <= '0;
            armed <= 1'b0;
            out_q <= decode(HOLD);
        end else begin
            case (state)
                HOLD: begin
                    if (count >= HOLD_LAST) begin
                        state <= WAIT_CAL;
                        count <= '0;
                        armed <= 1'b0;
                        out_q <= decode(WAIT_CAL);
                    end else begin
                        count <= sat_inc(count);
                    end
                end
                WAIT_CAL: begin
                    if (armed && init) begin
                        state <= READY;
                        out_q <= decode(READY);
                    end else if (count >= CAL_LAST) begin
                        state <= FAIL;
                        out_q <= decode(FAIL);
                    end else begin
                        count <= sat_inc(count);
                        if (!init)
                            armed <= 1'b1;
                    end
                end
                READY: begin
                    if (!init) begin
                        state <= FAIL;
                        out_q <= decode(FAIL);
                    end
                end
                FAIL: begin
                end
            endcase
        end
    end

    assign {phy_rst_o, busy, phy_ready, cal_fail} = out_q;

endmodule

// File: tb/tb_dram_reset_seq.sv
`timescale 1ns/1ps
// tb_dram_reset_seq
// Self-checking bench for dram_reset_seq (RST_CYCLES=8, CAL_TIMEOUT=100).
// Each driven cycle, a timestamp-based reference model pushes the expected
// outputs for the next edge into a queue. A monitor pops and compares them
// after every rising edge. Directed scenarios measure pulse widths and
// latencies, and a randomized run follows them.
module tb_dram_reset_seq;

    localparam int RST          = 8;
    localparam int CAL          = 100;
    // Reset release is retimed through two flops before the sequence starts
    localparam int RST_SYNC_LAT = 2;

    localparam logic [31:0] OUT_HOLD  = 32'b1100;
    localparam logic [31:0] OUT_WAIT  = 32'b0100;
    localparam logic [31:0] OUT_READY = 32'b0010;
    localparam logic [31:0] OUT_FAIL  = 32'b0001;

    logic wb_clk_i        = 1'b0;
    logic wb_rst_n_i      = 1'b0;
    logic dram_reset_strb = 1'b0;
    logic phy_init_done   = 1'b0;
    logic phy_rst_o;
    logic phy_ready;
    logic cal_fail;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    dram_reset_seq #(
        .RST_CYCLES  (RST),
        .CAL_TIMEOUT (CAL)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_n_i      (wb_rst_n_i),
        .dram_reset_strb (dram_reset_strb),
        .phy_init_done   (phy_init_done),
        .phy_rst_o       (phy_rst_o),
        .phy_ready       (phy_ready),
        .cal_fail        (cal_fail),
        .busy            (busy)
    );

    initial begin
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // Reference model state. Phases are tracked by the edge index at which
    // they were entered, and durations are computed as differences.
    typedef enum {P_HOLD, P_WAIT, P_READY, P_FAIL} phase_t;
    phase_t phase       = P_HOLD;
    int     cyc         = 0;
    int     phase_start = 0;
    int     rel_left    = RST_SYNC_LAT;
    bit     low_seen    = 1'b0;
    bit     s0          = 1'b0;
    bit     s1          = 1'b0;
    logic [31:0] sbq[$];

    function automatic logic [31:0] out_vec();
        return {28'd0, phy_rst_o, busy, phy_ready, cal_fail};
    endfunction

    function automatic logic [31:0] expected_for(input phase_t p);
        case (p)
            P_HOLD:  return OUT_HOLD;
            P_WAIT:  return OUT_WAIT;
            P_READY: return OUT_READY;
            default: return OUT_FAIL;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances the model by one rising edge and queues what the DUT must show after it
    task automatic model_step(input bit strb, input bit raw, input bit rstn);
        bit init_now;
        cyc++;
        if (!rstn || rel_left > 0) begin
            if (!rstn)
                rel_left = RST_SYNC_LAT;
            else
                rel_left--;
            s0          = 1'b0;
            s1          = 1'b0;
            phase       = P_HOLD;
            phase_start = cyc;
            low_seen    = 1'b0;
        end else begin
            init_now = s1;
            s1       = s0;
            s0       = raw;
            if (strb) begin
                phase       = P_HOLD;
                phase_start = cyc;
            end else if (phase == P_HOLD) begin
                if (cyc - phase_start == RST) begin
                    phase       = P_WAIT;
                    phase_start = cyc;
                    low_seen    = 1'b0;
                end
            end else if (phase == P_WAIT) begin
                if (low_seen && init_now)
                    phase = P_READY;
                else if (cyc - phase_start == CAL)
                    phase = P_FAIL;
                else if (!init_now)
                    low_seen = 1'b1;
            end else if (phase == P_READY && !init_now) begin
                phase = P_FAIL;
            end
        end
        sbq.push_back(expected_for(phase));
    endtask

    task automatic applyStimulus(input bit strb, input bit raw, input bit rstn);
        @(negedge wb_clk_i);
        dram_reset_strb = strb;
        phy_init_done   = raw;
        wb_rst_n_i      = rstn;
        model_step(strb, raw, rstn);
    endtask

    // Scoreboard monitor
    initial begin
        logic [31:0] expv;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (sbq.size() > 0) begin
                expv = sbq.pop_front();
                checkOutput("sb_outputs", out_vec(), expv);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int hi;
        bit raw;
        bit strb;
        bit rstn;
        int toggle_range;
        int strb_range;

        // Power-on reset and release
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_vals", out_vec(), OUT_HOLD);
        applyStimulus(1'b0, 1'b0, 1'b1);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end while (phy_rst_o === 1'b1 && n < 40);
        checkOutput("poweron_release_to_fall", 32'(n), 32'(RST + RST_SYNC_LAT));

        // Calibration completes 20 cycles after the PHY reset falls
        repeat (19) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        while (phy_ready !== 1'b1 && n < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("ready_latency", 32'(n), 32'd3);
        checkOutput("ready_outputs", out_vec(), OUT_READY);

        // Strobe from READY with done held low: timeout, then sticky FAIL
        applyStimulus(1'b1, 1'b0, 1'b1);
        n = 0;
        for (int k = 1; k < 40; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (phy_rst_o === 1'b1) n++;
            else break;
        end
        checkOutput("strobe_hold_len", 32'(n), 32'(RST));
        n = 0;
        while (cal_fail !== 1'b1 && n < 200) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'(CAL));
        hi = 0;
        repeat (500) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (cal_fail === 1'b1) hi++;
        end
        checkOutput("fail_sticky", 32'(hi), 32'd500);

        // Second strobe on cycle 5 of HOLD restarts the full count
        applyStimulus(1'b1, 1'b0, 1'b1);
        n = 0;
        for (int k = 1; k < 40; k++) begin
            applyStimulus(k == 5, 1'b0, 1'b1);
            if (phy_rst_o === 1'b1) n++;
            else break;
        end
        checkOutput("restrobe_hold_len", 32'(n), 32'(RST + 5));

        // Strobe landing on the timeout edge wins
        n = 0;
        while (!(phase == P_WAIT && cyc + 1 - phase_start == CAL) && n < 300) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("strb_vs_timeout", out_vec(), OUT_HOLD);

        // Reach READY, then strobe with done stuck high
        repeat (RST + 5) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        while (phy_ready !== 1'b1 && n < 10) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("ready_again", 32'(phy_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        n = 0;
        for (int k = 1; k < 40; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (k == 1) checkOutput("strobe_drops_ready", out_vec(), OUT_HOLD);
            if (phy_rst_o === 1'b1) n++;
            else break;
        end
        checkOutput("stuck_done_hold_len", 32'(n), 32'(RST));
        hi = 0;
        repeat (40) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (phy_ready === 1'b1) hi++;
        end
        checkOutput("stale_done_rejected", 32'(hi), 32'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        while (phy_ready !== 1'b1 && n < 10) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("rearmed_ready", 32'(phy_ready), 32'd1);

        // Calibration lost while READY
        applyStimulus(1'b0, 1'b0, 1'b1);
        n = 0;
        while (cal_fail !== 1'b1 && n < 10) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("cal_lost_latency", 32'(n), 32'd3);

        // Asynchronous reset in the middle of WAIT_CAL
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (RST + 10) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("in_wait_cal", out_vec(), OUT_WAIT);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("async_rst", out_vec(), OUT_HOLD);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized traffic in three segments: fast calibration, slow or
        // stuck calibration, and frequent strobes
        raw = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            toggle_range = (k < 1000) ? 11 : (k < 2000) ? 150 : 20;
            strb_range   = (k < 2000) ? 90 : 8;
            strb = ($urandom_range(0, strb_range) == 0);
            if ($urandom_range(0, toggle_range) == 0) raw = ~raw;
            rstn = ($urandom_range(0, 700) != 0);
            applyStimulus(strb, raw, rstn);
        end
        applyStimulus(1'b0, raw, 1'b1);

        repeat (3) @(posedge wb_clk_i);
        #2;
        checkOutput("sb_drain", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_reset_seq.md
DRAM_RESET_SEQ -- requirements
Module: dram_reset_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 64: number of cycles phy_rst_o is held high per reset sequence; legal range 1..2^24-1.
REQ-002 SHALL have parameter CAL_TIMEOUT, default 1000000: maximum number of cycles spent waiting for calibration; legal range 4..2^24-1.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port dram_reset_strb, input, 1 bit: one-cycle software reset strobe from the DRAM register block.
REQ-006 SHALL have port phy_init_done, input, 1 bit: PHY calibration-complete level, asynchronous to wb_clk_i.
REQ-007 SHALL have port phy_rst_o, output, 1 bit: active-high reset to the DRAM PHY/controller.
REQ-008 SHALL have port phy_ready, output, 1 bit: calibration complete and held; feeds the register block's PHY-ready bit.
REQ-009 SHALL have port cal_fail, output, 1 bit: calibration timed out or was lost; feeds the register block's cal-fail bit.
REQ-010 SHALL have port busy, output, 1 bit: a reset sequence is in progress.

Function
REQ-011 SHALL pass phy_init_done through a 2-flop synchronizer; "init" below means the synchronizer output.
REQ-012 SHALL implement a FSM with states HOLD, WAIT_CAL, READY, FAIL, and one 24-bit cycle counter.
REQ-013 All outputs SHALL be registered and decoded from the state, not from inputs combinationally.
REQ-014 HOLD: phy_rst_o=1, busy=1, phy_ready=0, cal_fail=0.
REQ-015 HOLD: the counter SHALL increment each cycle; the FSM moves to WAIT_CAL after exactly RST_CYCLES cycles in HOLD.
REQ-016 WAIT_CAL: phy_rst_o=0, busy=1, phy_ready=0, cal_fail=0.
REQ-017 WAIT_CAL: the counter SHALL restart from zero on entry.
REQ-018 WAIT_CAL: an "armed" flag SHALL clear on entry and set the first cycle init==0; init==1 is accepted only while armed, which rejects a stale done level from before the reset.
REQ-019 WAIT_CAL: armed and init==1 SHALL move the FSM to READY on the next edge.
REQ-020 WAIT_CAL: if READY has not been reached after CAL_TIMEOUT cycles in WAIT_CAL, the FSM SHALL move to FAIL.
REQ-021 READY: phy_ready=1, others 0; if init falls to 0, the FSM SHALL move to FAIL (calibration lost).
REQ-022 FAIL: cal_fail=1, others 0; FAIL is sticky until dram_reset_strb or reset.
REQ-023 dram_reset_strb=1 in any state SHALL move the FSM to HOLD next edge with the counter cleared.
REQ-024 A strobe while in HOLD SHALL restart the full RST_CYCLES count.
REQ-025 On simultaneous events, dram_reset_strb SHALL take priority over init rising, init falling and timeout.
REQ-026 Within WAIT_CAL, success SHALL take priority over timeout in the same cycle.
REQ-027 The counter SHALL saturate rather than wrap; parameter values SHALL be checked at elaboration to fit 24 bits.

Reset
REQ-028 While wb_rst_n_i=0: state=HOLD, counter=0, armed=0, synchronizer flops=0, phy_rst_o=1, busy=1, phy_ready=0, cal_fail=0.
REQ-029 phy_rst_o SHALL assert asynchronously with wb_rst_n_i falling, including in the middle of a sequence.
REQ-030 After wb_rst_n_i deasserts, a full power-on sequence (HOLD, then WAIT_CAL) SHALL run with no strobe required.
REQ-031 Deassertion of wb_rst_n_i SHALL be taken synchronously to wb_clk_i.

Verification (RST_CYCLES=8, CAL_TIMEOUT=100)
REQ-032 Release reset, raise phy_init_done 20 cycles after phy_rst_o falls -> phy_rst_o high exactly 8 cycles; phy_ready=1 within 3 cycles of the raise; busy=0.
REQ-033 phy_init_done held 0 -> cal_fail=1 exactly 100 cycles after WAIT_CAL entry; stays 1 for 500 further cycles.
REQ-034 From READY, pulse dram_reset_strb -> next cycle phy_ready=0 and phy_rst_o=1 for 8 cycles; phy_init_done stuck high throughout -> not accepted until it is seen low, then high.
REQ-035 Strobe on cycle 5 of HOLD -> phy_rst_o high 13 cycles total; strobe in the same cycle as the timeout -> HOLD, cal_fail stays 0.
REQ-036 From READY, drop phy_init_done -> cal_fail=1 within 3 cycles; pull wb_rst_n_i low mid-WAIT_CAL -> phy_rst_o=1 immediately and all REQ-028 values hold.
